// File: rtl/param_irr_if.sv
// Interrupt request register bus: raw request lines, per-channel mode and
// mask, acknowledge strobe, and the latched/prioritised request outputs.
interface param_irr_if #(
  parameter int NUM_CHANNELS = 8
);
  localparam int IDX_W = $clog2(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0] peripheralInterrupts;
  logic [NUM_CHANNELS-1:0] levelMode;
  logic [NUM_CHANNELS-1:0] interruptMask;
  logic                    ackValid;
  logic [IDX_W-1:0]        ackChannel;
  logic [NUM_CHANNELS-1:0] interruptRequest;
  logic                    pendingAny;
  logic [IDX_W-1:0]        highestPending;

  // The side that raises requests, configures channels and acknowledges
  modport master (
    output peripheralInterrupts,
    output levelMode,
    output interruptMask,
    output ackValid,
    output ackChannel,
    input  interruptRequest,
    input  pendingAny,
    input  highestPending
  );

  // The interrupt request register itself
  modport slave (
    input  peripheralInterrupts,
    input  levelMode,
    input  interruptMask,
    input  ackValid,
    input  ackChannel,
    output interruptRequest,
    output pendingAny,
    output highestPending
  );
endinterface

// File: rtl/param_irr.sv
// Parameterised interrupt request register. Each raw request line is
// synchronised, then latched either as a sticky edge request (cleared by an
// acknowledge) or as a transparent level request. Masking only hides a
// channel from the pending/priority outputs; it never stops latching.
// Priority is fixed with the lowest channel index winning.
module param_irr #(
  parameter int NUM_CHANNELS = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  param_irr_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0] syncChain [SYNC_STAGES];
  logic [NUM_CHANNELS-1:0] syncOut;
  logic [NUM_CHANNELS-1:0] prevSync;
  logic [NUM_CHANNELS-1:0] modeReg;
  logic [NUM_CHANNELS-1:0] irrReg;
  logic [NUM_CHANNELS-1:0] irrNext;
  logic [NUM_CHANNELS-1:0] risingEdge;
  logic [NUM_CHANNELS-1:0] modeChange;
  logic [NUM_CHANNELS-1:0] ackHit;
  logic [NUM_CHANNELS-1:0] visible;
  logic [IDX_W-1:0]        highestIdx;

  assign syncOut    = syncChain[SYNC_STAGES-1];
  assign risingEdge = syncOut & ~prevSync;
  assign modeChange = bus.levelMode ^ modeReg;
  assign visible    = irrReg & ~bus.interruptMask;

  // One-hot decode of the acknowledge; indices beyond the last channel match nothing
  always_comb begin
    ackHit = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (bus.ackValid && (int'(bus.ackChannel) == i)) begin
        ackHit[i] = 1'b1;
      end
    end
  end

  // Per-channel next request state: a mode switch wipes the bit and swallows any
  // edge seen in that cycle, level channels follow the line, edge channels are
  // sticky with a new edge beating a simultaneous acknowledge
  always_comb begin
    irrNext = irrReg;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (modeChange[i]) begin
        irrNext[i] = 1'b0;
      end else if (bus.levelMode[i]) begin
        irrNext[i] = syncOut[i];
      end else if (risingEdge[i]) begin
        irrNext[i] = 1'b1;
      end else if (ackHit[i]) begin
        irrNext[i] = 1'b0;
      end
    end
  end

  // Synchroniser chain, edge-detect history, registered mode and the request register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        syncChain[s] <= '0;
      end
      prevSync <= '0;
      modeReg  <= '0;
      irrReg   <= '0;
    end else begin
      syncChain[0] <= bus.peripheralInterrupts;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        syncChain[s] <= syncChain[s-1];
      end
      prevSync <= syncOut;
      modeReg  <= bus.levelMode;
      irrReg   <= irrNext;
    end
  end

  // Fixed priority pick: scanning downward leaves the lowest visible index
  always_comb begin
    highestIdx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (visible[i]) begin
        highestIdx = IDX_W'(i);
      end
    end
  end

  assign bus.interruptRequest = irrReg;
  assign bus.pendingAny       = |visible;
  assign bus.highestPending   = highestIdx;
endmodule

// File: tb/tb_param_irr.sv
// Bench for param_irr: directed scenarios plus randomised traffic, checked by a
// scoreboard fed from a delay-line reference model of the request register.
module tb_param_irr;
  localparam int SYNC = 2;

  typedef struct packed {
    logic [7:0] irr;
    logic       any;
    logic [2:0] hi;
  } expT;

  logic clk;
  logic reset;

  param_irr_if #(.NUM_CHANNELS(8)) bus ();
  param_irr_if #(.NUM_CHANNELS(6)) bus6 ();

  param_irr #(.NUM_CHANNELS(8), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  param_irr #(.NUM_CHANNELS(6), .SYNC_STAGES(SYNC)) dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus6.slave)
  );

  int checkCount = 0;
  int passCount  = 0;

  expT expQ[$];

  // Reference model: line samples seen at past edges, last seen mode, request bits
  logic [7:0] hist [0:SYNC];
  logic [7:0] lastMode;
  logic [7:0] irrModel;

  logic [7:0] curPeriph;
  logic [7:0] curMode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expIrr, input logic expAny,
                             input logic [2:0] expHi);
    checkVal({name, ".irr"}, 32'(bus.interruptRequest), 32'(expIrr));
    checkVal({name, ".any"}, 32'(bus.pendingAny), 32'(expAny));
    checkVal({name, ".hi"}, 32'(bus.highestPending), 32'(expHi));
  endtask

  task automatic clearModel();
    for (int i = 0; i <= SYNC; i++) hist[i] = 8'h00;
    lastMode = 8'h00;
    irrModel = 8'h00;
  endtask

  // Build the expected visible outputs from the model request bits and the mask
  function automatic expT expected(input logic [7:0] irr, input logic [7:0] mask);
    expT e;
    logic [7:0] vis;
    int idx;
    vis   = irr & ~mask;
    e.irr = irr;
    e.any = (vis != 8'h00);
    e.hi  = 3'd0;
    idx = 0;
    while (idx < 8 && !vis[idx]) idx++;
    if (idx < 8) e.hi = 3'(idx);
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model across the
  // coming rising edge, queue the expectation, and return just after that edge
  task automatic applyStimulus(input logic [7:0] periph, input logic [7:0] mode,
                               input logic [7:0] mask, input logic ackV,
                               input logic [2:0] ackCh, input logic rstVal);
    logic [7:0] seenNow;
    logic [7:0] seenBefore;
    @(negedge clk);
    bus.peripheralInterrupts = periph;
    bus.levelMode            = mode;
    bus.interruptMask        = mask;
    bus.ackValid             = ackV;
    bus.ackChannel           = ackCh;
    reset                    = rstVal;
    if (rstVal) begin
      clearModel();
    end else begin
      seenNow    = hist[SYNC-1];
      seenBefore = hist[SYNC];
      for (int c = 0; c < 8; c++) begin
        if (mode[c] != lastMode[c]) irrModel[c] = 1'b0;
        else if (mode[c]) irrModel[c] = seenNow[c];
        else if (seenNow[c] && !seenBefore[c]) irrModel[c] = 1'b1;
        else if (ackV && int'(ackCh) == c) irrModel[c] = 1'b0;
      end
      for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
      hist[0]  = periph;
      lastMode = mode;
    end
    expQ.push_back(expected(irrModel, mask));
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: every cycle with an outstanding expectation is compared
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkVal("sb.irr", 32'(bus.interruptRequest), 32'(e.irr));
        checkVal("sb.any", 32'(bus.pendingAny), 32'(e.any));
        checkVal("sb.hi", 32'(bus.highestPending), 32'(e.hi));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.peripheralInterrupts  = 8'h00;
    bus.levelMode             = 8'h00;
    bus.interruptMask         = 8'h00;
    bus.ackValid              = 1'b0;
    bus.ackChannel            = 3'd0;
    bus6.peripheralInterrupts = 6'h00;
    bus6.levelMode            = 6'h00;
    bus6.interruptMask        = 6'h00;
    bus6.ackValid             = 1'b0;
    bus6.ackChannel           = 3'd0;
    clearModel();

    @(posedge clk);
    #2;
    checkOutput("reset", 8'h00, 1'b0, 3'd0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

    // Edge latch, hold after the line drops, then acknowledge
    applyStimulus(8'h08, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("edgeLat1", 8'h00, 1'b0, 3'd0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("edgeLat2", 8'h00, 1'b0, 3'd0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("edgeSet", 8'h08, 1'b1, 3'd3);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("edgeHold", 8'h08, 1'b1, 3'd3);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 3'd3, 1'b0);
    checkOutput("edgeAck", 8'h00, 1'b0, 3'd0);

    // Level mode: follows the line, ack is ignored
    applyStimulus(8'h01, 8'h01, 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h01, 8'h01, 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h01, 8'h01, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("levelSet", 8'h01, 1'b1, 3'd0);
    applyStimulus(8'h01, 8'h01, 8'h00, 1'b1, 3'd0, 1'b0);
    checkOutput("levelAck", 8'h01, 1'b1, 3'd0);
    applyStimulus(8'h00, 8'h01, 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h00, 8'h01, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("levelDrop1", 8'h01, 1'b1, 3'd0);
    applyStimulus(8'h00, 8'h01, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("levelDrop2", 8'h00, 1'b0, 3'd0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

    // Priority and masking
    applyStimulus(8'h24, 8'h00, 8'h04, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h04, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h04, 1'b0, 3'd0, 1'b0);
    checkOutput("maskOne", 8'h24, 1'b1, 3'd5);
    applyStimulus(8'h00, 8'h00, 8'h24, 1'b0, 3'd0, 1'b0);
    checkOutput("maskBoth", 8'h24, 1'b0, 3'd0);
    bus.interruptMask = 8'h00;
    #1;
    checkOutput("unmaskNow", 8'h24, 1'b1, 3'd2);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 3'd2, 1'b0);
    checkOutput("ackLow", 8'h20, 1'b1, 3'd5);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 3'd5, 1'b0);

    // New edge in the same cycle as its ack: the set wins
    applyStimulus(8'h40, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h40, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 3'd6, 1'b0);
    checkOutput("setWins", 8'h40, 1'b1, 3'd6);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 3'd6, 1'b0);
    checkOutput("ackSix", 8'h00, 1'b0, 3'd0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 3'd6, 1'b0);
    checkOutput("ackZeroBit", 8'h00, 1'b0, 3'd0);

    // Reset mid-operation with line 1 held high
    applyStimulus(8'hFF, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h02, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h02, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("allSet", 8'hFF, 1'b1, 3'd0);
    #1;
    reset = 1'b1;
    clearModel();
    #1;
    checkOutput("midReset", 8'h00, 1'b0, 3'd0);
    applyStimulus(8'h02, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1);
    applyStimulus(8'h02, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1);
    applyStimulus(8'h02, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("rel1", 8'h00, 1'b0, 3'd0);
    applyStimulus(8'h02, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("rel2", 8'h00, 1'b0, 3'd0);
    applyStimulus(8'h02, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("rel3", 8'h02, 1'b1, 3'd1);

    // Randomised traffic against the model
    curPeriph = 8'h02;
    curMode   = 8'h00;
    for (int n = 0; n < 600; n++) begin
      logic [7:0] maskR;
      logic       ackR;
      logic [2:0] chR;
      logic       rstR;
      curPeriph = curPeriph ^ (8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 31) == 0) curMode[$urandom_range(0, 7)] ^= 1'b1;
      maskR = 8'($urandom);
      ackR  = 1'($urandom_range(0, 1));
      chR   = 3'($urandom);
      rstR  = ($urandom_range(0, 199) == 0);
      applyStimulus(curPeriph, curMode, maskR, ackR, chR, rstR);
    end
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

    // Six-channel instance: acknowledges for nonexistent channels are ignored
    @(negedge clk);
    bus6.peripheralInterrupts = 6'h3F;
    @(negedge clk);
    bus6.peripheralInterrupts = 6'h00;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkVal("six.latch", 32'(bus6.interruptRequest), 32'h3F);
    @(negedge clk);
    bus6.ackValid   = 1'b1;
    bus6.ackChannel = 3'd6;
    @(posedge clk);
    #2;
    checkVal("six.ack6", 32'(bus6.interruptRequest), 32'h3F);
    @(negedge clk);
    bus6.ackChannel = 3'd7;
    @(posedge clk);
    #2;
    checkVal("six.ack7", 32'(bus6.interruptRequest), 32'h3F);
    @(negedge clk);
    bus6.ackChannel = 3'd5;
    @(posedge clk);
    #2;
    checkVal("six.ack5", 32'(bus6.interruptRequest), 32'h1F);
    checkVal("six.hi", 32'(bus6.highestPending), 32'h0);
    @(negedge clk);
    bus6.ackValid = 1'b0;

    @(posedge clk);
    @(posedge clk);
    #3;
    checkVal("drain", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
